// File: rtl/exc_pkg.sv
// Shared constants for the exception responder: CP0 register numbers, ExcCodes,
// FSM state encoding and exc_src request-line indices.
package exc_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ENTER   = 3'd1;
   localparam logic [2:0] ST_HANDLER = 3'd2;
   localparam logic [2:0] ST_RETURN  = 3'd3;
   localparam logic [2:0] ST_HALT    = 3'd4;

   localparam int SRC_RI_OP    = 0;
   localparam int SRC_RI_FUNCT = 1;
   localparam int SRC_OV       = 2;
   localparam int SRC_ADEL     = 3;
   localparam int SRC_ADES     = 4;

   typedef struct packed {
      logic       valid;
      logic [4:0] excCode;
      logic       isAddrErr;
   } excReq_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: lowest set exc_src bit selects the ExcCode.
module exc_prio_enc
   import exc_pkg::*;
(
   input  logic [4:0] excSrc,
   output excReq_t    req
);

   // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
   always_comb begin
      req = '0;
      if (excSrc[SRC_RI_OP])         req = '{valid: 1'b1, excCode: EXC_RI,   isAddrErr: 1'b0};
      else if (excSrc[SRC_RI_FUNCT]) req = '{valid: 1'b1, excCode: EXC_RI,   isAddrErr: 1'b0};
      else if (excSrc[SRC_OV])       req = '{valid: 1'b1, excCode: EXC_OV,   isAddrErr: 1'b0};
      else if (excSrc[SRC_ADEL])     req = '{valid: 1'b1, excCode: EXC_ADEL, isAddrErr: 1'b1};
      else if (excSrc[SRC_ADES])     req = '{valid: 1'b1, excCode: EXC_ADES, isAddrErr: 1'b1};
   end

endmodule

// File: rtl/exc_handler_cp0.sv
// Exception responder: captures faulting context into CP0, flushes and redirects
// the PC to the handler, returns on ERET, and halts on a nested exception.
module exc_handler_cp0
   import exc_pkg::*;
#(
   parameter int                 DATA_W       = 32,
   parameter logic [DATA_W-1:0]  HANDLER_ADDR = 32'h0000_0080
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        exc_src,
   input  logic [DATA_W-1:0] exc_pc,
   input  logic [DATA_W-1:0] exc_bad_addr,
   input  logic              eret,
   input  logic              mtc0_en,
   input  logic [4:0]        cp0_waddr,
   input  logic [DATA_W-1:0] cp0_wdata,
   input  logic [4:0]        cp0_raddr,
   output logic [DATA_W-1:0] cp0_rdata,
   output logic              flush,
   output logic              pc_redirect,
   output logic [DATA_W-1:0] redirect_pc,
   output logic              in_handler,
   output logic              halt
);

   logic [2:0]        state;
   logic [DATA_W-1:0] badVAddr;
   logic [DATA_W-1:0] epc;
   logic [4:0]        excCode;
   logic              exl;
   logic              ie;
   excReq_t           req;

   exc_prio_enc uPrioEnc (
      .excSrc (exc_src),
      .req    (req)
   );

   // NOTE: non-blocking assignments for all state; where a software write and a
   // hardware update hit the same field, the later statement in this block wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         badVAddr <= '0;
         epc      <= '0;
         excCode  <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
      end else if (state != ST_HALT) begin
         if (mtc0_en) begin
            if (cp0_waddr == CP0_STATUS) begin
               ie  <= cp0_wdata[0];
               exl <= cp0_wdata[1];
            end
            if (cp0_waddr == CP0_EPC) epc <= cp0_wdata;
         end

         case (state)
            ST_IDLE: begin
               if (req.valid) begin
                  epc     <= exc_pc;
                  excCode <= req.excCode;
                  exl     <= 1'b1;
                  if (req.isAddrErr) badVAddr <= exc_bad_addr;
                  state   <= ST_ENTER;
               end
            end
            ST_ENTER:   state <= ST_HANDLER;
            ST_HANDLER: begin
               if (exc_src != '0) begin
                  state <= ST_HALT;
               end else if (eret) begin
                  exl   <= 1'b0;
                  state <= ST_RETURN;
               end
            end
            ST_RETURN:  state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   // Redirect outputs are suppressed while rst is held so a reset cycle never steers the PC.
   always_comb begin
      flush       = 1'b0;
      pc_redirect = 1'b0;
      redirect_pc = '0;
      if (!rst) begin
         case (state)
            ST_ENTER: begin
               flush       = 1'b1;
               pc_redirect = 1'b1;
               redirect_pc = HANDLER_ADDR;
            end
            ST_RETURN: begin
               flush       = 1'b1;
               pc_redirect = 1'b1;
               redirect_pc = epc;
            end
            ST_HALT: flush = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      cp0_rdata = '0;
      case (cp0_raddr)
         CP0_BADVADDR: cp0_rdata = badVAddr;
         CP0_STATUS:   cp0_rdata = {{(DATA_W-2){1'b0}}, exl, ie};
         CP0_CAUSE:    cp0_rdata = {{(DATA_W-7){1'b0}}, excCode, 2'b00};
         CP0_EPC:      cp0_rdata = epc;
         default:      cp0_rdata = '0;
      endcase
   end

   assign in_handler = exl;
   assign halt       = (state == ST_HALT);

endmodule

// File: tb/tb_exc_handler_cp0.sv
// Bench for exc_handler_cp0: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the exception rules.
module tb_exc_handler_cp0;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  exc_src;
   logic [31:0] exc_pc;
   logic [31:0] exc_bad_addr;
   logic        eret;
   logic        mtc0_en;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        flush;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;
   logic        halt;

   exc_handler_cp0 dut (
      .clk          (clk),
      .rst          (rst),
      .exc_src      (exc_src),
      .exc_pc       (exc_pc),
      .exc_bad_addr (exc_bad_addr),
      .eret         (eret),
      .mtc0_en      (mtc0_en),
      .cp0_waddr    (cp0_waddr),
      .cp0_wdata    (cp0_wdata),
      .cp0_raddr    (cp0_raddr),
      .cp0_rdata    (cp0_rdata),
      .flush        (flush),
      .pc_redirect  (pc_redirect),
      .redirect_pc  (redirect_pc),
      .in_handler   (in_handler),
      .halt         (halt)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit checkEn = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase of the exception life-cycle and the architectural CP0 values.
   typedef enum {P_IDLE, P_ENTER, P_HANDLER, P_RETURN, P_HALT} phase_e;
   phase_e      mPhase;
   logic [31:0] mBad, mEpc, mCause;
   bit          mExl, mIe;
   int          codeOfBit[5] = '{10, 10, 12, 4, 5};

   function automatic int lowestBit(input logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] modelRead(input logic [4:0] a);
      case (a)
         5'd8:    return mBad;
         5'd12:   return {30'd0, mExl, mIe};
         5'd13:   return mCause;
         5'd14:   return mEpc;
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelStep();
      int w;
      if (rst) begin
         mPhase = P_IDLE; mBad = 0; mEpc = 0; mCause = 0; mExl = 0; mIe = 0;
         return;
      end
      if (mPhase == P_HALT) return;
      if (mtc0_en && cp0_waddr == 5'd12) begin mIe = cp0_wdata[0]; mExl = cp0_wdata[1]; end
      if (mtc0_en && cp0_waddr == 5'd14) mEpc = cp0_wdata;
      case (mPhase)
         P_IDLE: begin
            w = lowestBit(exc_src);
            if (w >= 0) begin
               mEpc = exc_pc;
               mCause = codeOfBit[w] * 4;
               mExl = 1;
               if (w >= 3) mBad = exc_bad_addr;
               mPhase = P_ENTER;
            end
         end
         P_ENTER:   mPhase = P_HANDLER;
         P_HANDLER: begin
            if (exc_src != 0) mPhase = P_HALT;
            else if (eret) begin mExl = 0; mPhase = P_RETURN; end
         end
         P_RETURN:  mPhase = P_IDLE;
         default:   ;
      endcase
   endtask

   // Compare process: every non-reset cycle, on the falling edge.
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         check("flush", {31'd0, flush},
               {31'd0, (mPhase == P_ENTER || mPhase == P_RETURN || mPhase == P_HALT)});
         check("pc_redirect", {31'd0, pc_redirect}, {31'd0, (mPhase == P_ENTER || mPhase == P_RETURN)});
         check("redirect_pc", redirect_pc,
               mPhase == P_ENTER ? 32'h80 : (mPhase == P_RETURN ? mEpc : 32'd0));
         check("in_handler", {31'd0, in_handler}, {31'd0, mExl});
         check("halt", {31'd0, halt}, {31'd0, mPhase == P_HALT});
         check("cp0_rdata", cp0_rdata, modelRead(cp0_raddr));
      end
   end

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic quiet();
      exc_src = 0; eret = 0; mtc0_en = 0; cp0_waddr = 0; cp0_wdata = 0;
   endtask

   task automatic readReg(input logic [4:0] a, output logic [31:0] v);
      cp0_raddr = a;
      #1;
      v = cp0_rdata;
   endtask

   logic [31:0] rv;
   logic [4:0]  addrPick[5] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd3};

   initial begin
      rst = 1; quiet(); exc_pc = 0; exc_bad_addr = 0; cp0_raddr = 5'd12;
      tick(); tick();
      rst = 0; checkEn = 1;

      // Reset state
      readReg(5'd8, rv);  check("reset_badvaddr", rv, 32'h0);
      readReg(5'd12, rv); check("reset_status", rv, 32'h0);
      readReg(5'd13, rv); check("reset_cause", rv, 32'h0);
      readReg(5'd14, rv); check("reset_epc", rv, 32'h0);
      check("reset_halt", {31'd0, halt}, 32'h0);

      // Overflow entry
      exc_src = 5'b00100; exc_pc = 32'h40;
      tick(); quiet();
      check("ov_flush", {31'd0, flush}, 32'h1);
      check("ov_redirect", {31'd0, pc_redirect}, 32'h1);
      check("ov_redirect_pc", redirect_pc, 32'h80);
      check("ov_in_handler", {31'd0, in_handler}, 32'h1);
      readReg(5'd13, rv); check("ov_cause", rv, 32'h30);
      readReg(5'd14, rv); check("ov_epc", rv, 32'h40);
      readReg(5'd12, rv); check("ov_status", rv, 32'h2);
      tick(); eret = 1; tick(); eret = 0;
      check("ov_ret_pc", redirect_pc, 32'h40);
      tick();

      // Multi-bit request: bit0 wins, no BadVAddr capture
      exc_src = 5'b11001; exc_pc = 32'h60; exc_bad_addr = 32'h1003;
      tick(); quiet();
      readReg(5'd13, rv); check("ri_cause", rv, 32'h28);
      readReg(5'd8, rv);  check("ri_badvaddr", rv, 32'h0);
      tick(); eret = 1; tick(); eret = 0; tick();

      // Load misaligned, then ERET three cycles later
      exc_src = 5'b01000; exc_pc = 32'h20; exc_bad_addr = 32'h1003;
      tick(); quiet();
      readReg(5'd8, rv);  check("adel_badvaddr", rv, 32'h1003);
      readReg(5'd13, rv); check("adel_cause", rv, 32'h10);
      tick(); tick(); tick();
      eret = 1; tick(); eret = 0;
      check("adel_ret_redirect", {31'd0, pc_redirect}, 32'h1);
      check("adel_ret_pc", redirect_pc, 32'h20);
      readReg(5'd12, rv); check("adel_ret_status", rv, 32'h0);
      tick();
      check("adel_idle_redirect", {31'd0, pc_redirect}, 32'h0);

      // Nested exception halts; rst clears everything
      exc_src = 5'b00100; exc_pc = 32'h44;
      tick(); quiet(); tick();
      exc_src = 5'b00010; exc_pc = 32'h99;
      tick(); quiet();
      eret = 1; mtc0_en = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hdead;
      repeat (12) tick();
      quiet();
      check("halt_sticky", {31'd0, halt}, 32'h1);
      readReg(5'd14, rv); check("halt_epc", rv, 32'h44);
      rst = 1; tick(); rst = 0;
      check("rst_halt", {31'd0, halt}, 32'h0);
      readReg(5'd8, rv);  check("rst_badvaddr", rv, 32'h0);
      readReg(5'd12, rv); check("rst_status", rv, 32'h0);
      readReg(5'd13, rv); check("rst_cause", rv, 32'h0);
      readReg(5'd14, rv); check("rst_epc", rv, 32'h0);

      // MTC0 versus hardware capture, dropped Cause write, Status write
      exc_src = 5'b00100; exc_pc = 32'h50;
      mtc0_en = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234;
      tick(); quiet();
      readReg(5'd14, rv); check("mtc0_conflict_epc", rv, 32'h50);
      tick(); eret = 1; tick(); eret = 0; tick();
      mtc0_en = 1; cp0_waddr = 5'd13; cp0_wdata = 32'hffff_ffff;
      tick(); quiet();
      readReg(5'd13, rv); check("mtc0_cause_dropped", rv, 32'h30);
      mtc0_en = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h1;
      tick(); quiet();
      readReg(5'd12, rv); check("mtc0_status", rv, 32'h1);

      // ERET in IDLE ignored; requests during ENTER ignored
      eret = 1; tick(); eret = 0;
      check("idle_eret_flush", {31'd0, flush}, 32'h0);
      check("idle_eret_redirect", {31'd0, pc_redirect}, 32'h0);
      exc_src = 5'b00100; exc_pc = 32'h70;
      tick();
      exc_src = 5'b00001; exc_pc = 32'h99;
      tick(); quiet();
      readReg(5'd14, rv); check("enter_ignored_epc", rv, 32'h70);
      check("enter_ignored_halt", {31'd0, halt}, 32'h0);
      eret = 1; tick(); eret = 0; tick();

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         rst          = ($urandom_range(0, 39) == 0);
         exc_src      = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         exc_pc       = $urandom;
         exc_bad_addr = $urandom;
         eret         = ($urandom_range(0, 3) == 0);
         mtc0_en      = ($urandom_range(0, 4) == 0);
         cp0_waddr    = addrPick[$urandom_range(0, 4)];
         cp0_wdata    = $urandom;
         cp0_raddr    = addrPick[$urandom_range(0, 4)];
         tick();
      end

      rst = 0; quiet();
      tick();
      checkEn = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
